// File: rtl/ctech_lib_arb_pkg.sv
// Shared types and helpers for the ctech-library round-robin arbiter.
package ctech_lib_arb_pkg;

  localparam int unsigned ARB_ST_W = 2;

  typedef enum logic [ARB_ST_W-1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT  = 2'd1,
    ARB_HOLD = 2'd2
  } arb_st_e;

  // Index of the (single) set bit; 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [63:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (oh[6'(i)]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/ctech_lib_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module ctech_lib_rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] oh_c,
  output logic [IDW-1:0]   idx_c,
  output logic             any_c
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] j;

  always_comb begin
    oh_c  = '0;
    idx_c = '0;
    any_c = 1'b0;
    sum   = '0;
    j     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      j = sum[IDW-1:0];
      if (!any_c && req_i[j]) begin
        any_c   = 1'b1;
        oh_c[j] = 1'b1;
        idx_c   = j;
      end
    end
  end

endmodule

// File: rtl/ctech_lib_rr_arb_ctrl.sv
// Round-robin arbiter with burst lock and hold limit; all grant outputs are flop-driven.
module ctech_lib_rr_arb_ctrl
  import ctech_lib_arb_pkg::*;
#(
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned HOLD_MAX = 8,
  localparam int unsigned IDW      = $clog2(N_REQ),
  localparam int unsigned HCW      = $clog2(HOLD_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [IDW-1:0]   gnt_id,
  output logic [HCW-1:0]   hold_cnt
);

  arb_st_e          st_q, st_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]   hold_q, hold_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             own_req, own_lock, others_wait;

  ctech_lib_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .oh_c  (pick_oh),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Rotation only makes sense when a waiting requester could actually be granted.
  assign own_req     = |(req & gnt_q);
  assign own_lock    = |(lock & gnt_q);
  assign others_wait = en & (|(req & ~gnt_q));

  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    unique case (st_q)
      ARB_IDLE: begin
        if (en && pick_any) begin
          st_d   = ARB_GNT;
          gnt_d  = pick_oh;
          ptr_d  = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + IDW'(1);
          hold_d = '0;
        end
      end
      ARB_GNT: begin
        if (!own_req || (!own_lock && others_wait)) begin
          st_d  = ARB_IDLE;
          gnt_d = '0;
        end else if (own_lock) begin
          st_d   = ARB_HOLD;
          hold_d = HCW'(1);
        end
      end
      ARB_HOLD: begin
        if (!own_req || (hold_q == HCW'(HOLD_MAX) && others_wait)) begin
          st_d   = ARB_IDLE;
          gnt_d  = '0;
          hold_d = '0;
        end else if (!own_lock) begin
          st_d   = ARB_GNT;
          hold_d = '0;
        end else if (hold_q != HCW'(HOLD_MAX)) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: begin
        st_d   = ARB_IDLE;
        gnt_d  = '0;
        hold_d = '0;
      end
    endcase
    gnt_vld_d = |gnt_d;
    gnt_id_d  = IDW'(onehot_to_idx(64'(gnt_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      st_q      <= st_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_vld  = gnt_vld_q;
  assign gnt_id   = gnt_id_q;
  assign hold_cnt = hold_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_req_prev: assert property (@(posedge clk) disable iff (rst) ((gnt_q & ~$past(req)) == '0));
  a_hold_max: assert property (@(posedge clk) disable iff (rst) (hold_q <= HCW'(HOLD_MAX)));

endmodule
